// File: rtl/rect_fill_engine.sv
// -----------------------------------------------------------------------------
// rect_fill_engine
//
// Rectangle-fill engine for the 1-bit framebuffer write port. It accepts one
// rectangle command per valid/ready handshake, clips the far corner to the
// screen, then emits one framebuffer write per cycle in raster order. A reject
// (empty rectangle after clipping) retires immediately and sets a sticky error.
//
// Optional feature (macro RECT_FILL_PATTERN_EN): when defined, a command with
// cmd_pattern=1 fills a checkerboard anchored to absolute screen coordinates
// (fb_din = color ^ x[0] ^ y[0]). When undefined, cmd_pattern is ignored.
//
// Ports:
//   clk          clock (also the framebuffer write clock)
//   rst          asynchronous, active-low reset
//   cmd_valid    command present
//   cmd_ready    engine can accept a command (IDLE only)
//   cmd_x0/x1    inclusive column bounds
//   cmd_y0/y1    inclusive row bounds
//   cmd_color    fill value
//   cmd_pattern  checkerboard request (optional feature only)
//   abort        stop the current fill after the write presented this cycle
//   fb_we        framebuffer write enable
//   fb_addr      framebuffer address, {y, x[log2(H_RES)-1:0]}
//   fb_din       framebuffer write data
//   busy         high in FILL and DONE
//   done         one-cycle pulse when a command retires
//   err          sticky reject flag, cleared by the next accepted command
// -----------------------------------------------------------------------------
module rect_fill_engine #(
    parameter int H_RES       = 1024,
    parameter int V_RES       = 768,
    parameter int COORD_WIDTH = 11,
    parameter int ADDR_WIDTH  = 20
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [COORD_WIDTH-1:0] cmd_x0,
    input  logic [COORD_WIDTH-1:0] cmd_x1,
    input  logic [COORD_WIDTH-1:0] cmd_y0,
    input  logic [COORD_WIDTH-1:0] cmd_y1,
    input  logic                   cmd_color,
    input  logic                   cmd_pattern,
    input  logic                   abort,
    output logic                   fb_we,
    output logic [ADDR_WIDTH-1:0]  fb_addr,
    output logic                   fb_din,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    localparam int XW = $clog2(H_RES);
    localparam logic [COORD_WIDTH-1:0] X_MAX = COORD_WIDTH'(H_RES - 1);
    localparam logic [COORD_WIDTH-1:0] Y_MAX = COORD_WIDTH'(V_RES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Command registers
    logic [COORD_WIDTH-1:0] x0_q, x0_d;
    logic [COORD_WIDTH-1:0] cx1_q, cx1_d;
    logic [COORD_WIDTH-1:0] cy1_q, cy1_d;
    logic                   color_q, color_d;
    logic                   pattern_q, pattern_d;

    // Current pixel (the one presented on fb_addr while fb_we is high)
    logic [COORD_WIDTH-1:0] x_q, x_d;
    logic [COORD_WIDTH-1:0] y_q, y_d;

    // Registered outputs
    logic                   cmd_ready_q, cmd_ready_d;
    logic                   fb_we_q, fb_we_d;
    logic [ADDR_WIDTH-1:0]  fb_addr_q, fb_addr_d;
    logic                   fb_din_q, fb_din_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;

    logic [COORD_WIDTH-1:0] cx1_clip;
    logic [COORD_WIDTH-1:0] cy1_clip;
    logic                   accept;
    logic                   reject;
    logic                   last_px;
    logic                   pix_din;

    assign accept   = cmd_valid && cmd_ready_q;
    assign cx1_clip = (cmd_x1 > X_MAX) ? X_MAX : cmd_x1;
    assign cy1_clip = (cmd_y1 > Y_MAX) ? Y_MAX : cmd_y1;
    assign reject   = (cmd_x0 > cx1_clip) || (cmd_y0 > cy1_clip);
    assign last_px  = (x_q == cx1_q) && (y_q == cy1_q);

    // -------------------------------------------------------------------------
    // State register and datapath flops
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            x0_q        <= '0;
            cx1_q       <= '0;
            cy1_q       <= '0;
            color_q     <= 1'b0;
            pattern_q   <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            cmd_ready_q <= 1'b1;
            fb_we_q     <= 1'b0;
            fb_addr_q   <= '0;
            fb_din_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            x0_q        <= x0_d;
            cx1_q       <= cx1_d;
            cy1_q       <= cy1_d;
            color_q     <= color_d;
            pattern_q   <= pattern_d;
            x_q         <= x_d;
            y_q         <= y_d;
            cmd_ready_q <= cmd_ready_d;
            fb_we_q     <= fb_we_d;
            fb_addr_q   <= fb_addr_d;
            fb_din_q    <= fb_din_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = reject ? S_DONE : S_FILL;
                end
            end
            S_FILL: begin
                // Abort only ends the fill after the write already on the bus.
                if (last_px || abort) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Output / datapath logic. Outputs are computed from state_d so they are
    // registered yet line up with the state they describe.
    // -------------------------------------------------------------------------
    always_comb begin
        x0_d      = x0_q;
        cx1_d     = cx1_q;
        cy1_d     = cy1_q;
        color_d   = color_q;
        pattern_d = pattern_q;
        x_d       = x_q;
        y_d       = y_q;
        err_d     = err_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    x0_d      = cmd_x0;
                    cx1_d     = cx1_clip;
                    cy1_d     = cy1_clip;
                    color_d   = cmd_color;
                    pattern_d = cmd_pattern;
                    x_d       = cmd_x0;
                    y_d       = cmd_y0;
                    err_d     = reject;
                end
            end
            S_FILL: begin
                if (state_d == S_FILL) begin
                    if (x_q == cx1_q) begin
                        x_d = x0_q;
                        y_d = y_q + 1'b1;
                    end else begin
                        x_d = x_q + 1'b1;
                    end
                end
            end
            default: ;
        endcase

`ifdef RECT_FILL_PATTERN_EN
        pix_din = color_d ^ (pattern_d & (x_d[0] ^ y_d[0]));
`else
        pix_din = color_d;
`endif

        cmd_ready_d = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);
        fb_we_d     = (state_d == S_FILL);

        // Address and data hold their last value outside FILL.
        fb_addr_d = fb_addr_q;
        fb_din_d  = fb_din_q;
        if (fb_we_d) begin
            fb_addr_d = ADDR_WIDTH'({y_d, x_d[XW-1:0]});
            fb_din_d  = pix_din;
        end
    end

`ifndef RECT_FILL_PATTERN_EN
    // The pattern request is latched but has no effect in this build.
    logic unused_pattern;
    assign unused_pattern = pattern_q;
`endif

    assign cmd_ready = cmd_ready_q;
    assign fb_we     = fb_we_q;
    assign fb_addr   = fb_addr_q;
    assign fb_din    = fb_din_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_rect_fill_engine.sv
// -----------------------------------------------------------------------------
// tb_rect_fill_engine
//
// Scoreboard bench: each command pushes its expected writes and its expected
// retirement (err value at done) into queues; a monitor on the falling edge
// pops and compares whenever fb_we or done is high. The driver checks timing
// (first-write latency, accept-to-ready spacing, sticky err).
// -----------------------------------------------------------------------------
module tb_rect_fill_engine;

    localparam int H_RES       = 1024;
    localparam int V_RES       = 768;
    localparam int COORD_WIDTH = 11;
    localparam int ADDR_WIDTH  = 20;

`ifdef RECT_FILL_PATTERN_EN
    localparam bit PATTERN_ON = 1'b1;
`else
    localparam bit PATTERN_ON = 1'b0;
`endif

    logic                   clk;
    logic                   rst;
    logic                   cmd_valid;
    logic                   cmd_ready;
    logic [COORD_WIDTH-1:0] cmd_x0, cmd_x1, cmd_y0, cmd_y1;
    logic                   cmd_color;
    logic                   cmd_pattern;
    logic                   abort;
    logic                   fb_we;
    logic [ADDR_WIDTH-1:0]  fb_addr;
    logic                   fb_din;
    logic                   busy;
    logic                   done;
    logic                   err;

    rect_fill_engine #(
        .H_RES      (H_RES),
        .V_RES      (V_RES),
        .COORD_WIDTH(COORD_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_x0     (cmd_x0),
        .cmd_x1     (cmd_x1),
        .cmd_y0     (cmd_y0),
        .cmd_y1     (cmd_y1),
        .cmd_color  (cmd_color),
        .cmd_pattern(cmd_pattern),
        .abort      (abort),
        .fb_we      (fb_we),
        .fb_addr    (fb_addr),
        .fb_din     (fb_din),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int addr;
        bit din;
    } wr_t;

    wr_t wr_q[$];
    bit  done_q[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Reference pixel value: colour, optionally flipped on odd-parity squares.
    function automatic bit exp_din(input int x, input int y, input bit c, input bit p);
        bit odd;
        odd = ((x + y) % 2) == 1;
        return c ^ (PATTERN_ON && p && odd);
    endfunction

    // Monitor: pops the scoreboard whenever the DUT presents a write or done.
    always @(negedge clk) begin
        if (rst) begin
            if (fb_we) begin
                if (wr_q.size() == 0) begin
                    check("unexpected_write_addr", int'(fb_addr), -1);
                end else begin
                    wr_t e;
                    e = wr_q.pop_front();
                    check("wr_addr", int'(fb_addr), e.addr);
                    check("wr_din", int'(fb_din), int'(e.din));
                end
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    bit e_err;
                    e_err = done_q.pop_front();
                    check("done_err", int'(err), int'(e_err));
                end
            end
        end
    end

    // Issue one command and follow it until cmd_ready returns. abort_k > 0
    // raises abort during the abort_k-th cycle after accept; reset_k > 0
    // pulls reset during the reset_k-th cycle after accept.
    task automatic run_cmd(input int x0, input int x1, input int y0, input int y1,
                           input bit c, input bit p, input int abort_k, input int reset_k);
        int  cx1, cy1, total, n, cnt, cyc;
        bit  rej;

        @(negedge clk);
        cyc = 0;
        while (!cmd_ready && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        if (!cmd_ready) check("ready_wait_timeout", 0, 1);

        cx1   = (x1 > H_RES - 1) ? H_RES - 1 : x1;
        cy1   = (y1 > V_RES - 1) ? V_RES - 1 : y1;
        rej   = (x0 > cx1) || (y0 > cy1);
        total = rej ? 0 : (cx1 - x0 + 1) * (cy1 - y0 + 1);
        n     = (abort_k > 0 && abort_k < total) ? abort_k : total;

        cnt = 0;
        for (int y = y0; y <= cy1 && cnt < n; y++) begin
            for (int x = x0; x <= cx1 && cnt < n; x++) begin
                wr_t w;
                w.addr = y * H_RES + x;
                w.din  = exp_din(x, y, c, p);
                wr_q.push_back(w);
                cnt++;
            end
        end
        done_q.push_back(rej);

        cmd_x0      = COORD_WIDTH'(x0);
        cmd_x1      = COORD_WIDTH'(x1);
        cmd_y0      = COORD_WIDTH'(y0);
        cmd_y1      = COORD_WIDTH'(y1);
        cmd_color   = c;
        cmd_pattern = p;
        cmd_valid   = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid   = 1'b0;
        cmd_x0      = COORD_WIDTH'($urandom);
        cmd_x1      = COORD_WIDTH'($urandom);
        cmd_color   = 1'($urandom);

        $display("CMD (%0d,%0d)-(%0d,%0d) color=%0b pat=%0b abort_k=%0d reset_k=%0d writes=%0d reject=%0b",
                 x0, y0, x1, y1, c, p, abort_k, reset_k, n, rej);

        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                check("first_cycle_we", int'(fb_we), int'(n > 0));
                check("first_cycle_done", int'(done), int'(n == 0));
            end
            if (reset_k > 0 && cyc == reset_k) begin
                #1;
                rst = 1'b0;
                #1;
                check("reset_we_async", int'(fb_we), 0);
                wr_q.delete();
                done_q.delete();
                @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                check("reset_ready", int'(cmd_ready), 1);
                check("reset_busy", int'(busy), 0);
                repeat (5) @(negedge clk);
                check("reset_no_writes", int'(fb_we), 0);
                return;
            end
            if (abort_k > 0 && cyc == abort_k)     abort = 1'b1;
            if (abort_k > 0 && cyc == abort_k + 1) abort = 1'b0;
        end while (!cmd_ready && cyc < n + 60);
        abort = 1'b0;

        check("ready_spacing", cyc, n + 2);
        check("err_after", int'(err), int'(rej));
    endtask

    initial begin
        rst         = 1'b0;
        cmd_valid   = 1'b0;
        cmd_x0      = '0;
        cmd_x1      = '0;
        cmd_y0      = '0;
        cmd_y1      = '0;
        cmd_color   = 1'b0;
        cmd_pattern = 1'b0;
        abort       = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_cmd_ready", int'(cmd_ready), 1);
        check("rst_fb_we", int'(fb_we), 0);
        check("rst_fb_addr", int'(fb_addr), 0);
        check("rst_fb_din", int'(fb_din), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_err", int'(err), 0);

        // Directed cases
        run_cmd(0, 3, 0, 1, 1'b1, 1'b0, 0, 0);            // 8 writes, two rows
        run_cmd(1020, 1500, 766, 900, 1'b1, 1'b0, 0, 0);  // clipped corner
        run_cmd(10, 9, 5, 5, 1'b1, 1'b0, 0, 0);           // reject -> err
        run_cmd(2, 2, 2, 2, 1'b0, 1'b0, 0, 0);            // single pixel clears err
        run_cmd(0, 1023, 0, 767, 1'b1, 1'b0, 100, 0);     // abort on write 100
        run_cmd(0, 1, 0, 1, 1'b0, 1'b1, 0, 0);            // checkerboard request
        run_cmd(5, 8, 3, 3, 1'b1, 1'b0, 4, 0);            // abort on final pixel
        run_cmd(0, 7, 0, 3, 1'b1, 1'b0, 0, 5);            // reset at write 5 of 32
        run_cmd(100, 1100, 10, 10, 1'b0, 1'b1, 0, 0);     // x clip, width > screen gap
        run_cmd(3, 3, 800, 900, 1'b1, 1'b0, 0, 0);        // y0 off-screen -> reject

        // Randomised commands
        for (int i = 0; i < 40; i++) begin
            int x0, x1, y0, y1, ak;
            x0 = $urandom_range(0, 1040);
            x1 = x0 + $urandom_range(0, 10) - (($urandom_range(0, 6) == 0) ? 2 : 0);
            if (x1 < 0) x1 = 0;
            y0 = $urandom_range(0, 775);
            y1 = y0 + $urandom_range(0, 3);
            ak = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 20) : 0;
            run_cmd(x0, x1, y0, y1, 1'($urandom), 1'($urandom), ak, 0);
        end

        repeat (3) @(negedge clk);
        check("writes_outstanding", wr_q.size(), 0);
        check("dones_outstanding", done_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
